mem_bus_arbiter: RTL

- Sole owner of the 8-bit external RAM/IO bus.
- Arbitrates between the instruction-fetch requester (decoder side) and the load/store buffer.
- Serialises each granted request into 1–4 byte-wide bus beats, assembles or sign-extends read data, and returns it with a one-cycle done pulse.
- Sits between the core and the top-level mem_din/mem_dout/mem_a/mem_wr pins; honours rdy_in, clear and io_buffer_full.

---
 rtl/mem_bus_arbiter_if.sv | 50 +++++
 rtl/mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Core-side and pin-side signals of the external memory bus arbiter.
// The arbiter connects through the slave modport. The core, the RAM/IO pins
// and the testbench connect through the master modport.
interface mem_bus_arbiter_if;
  // Global qualifiers
  logic        rdy_in;
  logic        clear;

  // External RAM/IO pins
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  // Instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  // Load/store buffer requester
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic        ls_signed;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  // Status
  logic        busy;

  modport slave (
    input  rdy_in, clear, mem_din, io_buffer_full,
           if_req, if_addr,
           ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
    output mem_dout, mem_a, mem_wr,
           if_done, if_data, ls_done, ls_rdata, busy
  );

  modport master (
    output rdy_in, clear, mem_din, io_buffer_full,
           if_req, if_addr,
           ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
    input  mem_dout, mem_a, mem_wr,
           if_done, if_data, ls_done, ls_rdata, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: sole owner of the byte-wide external RAM/IO bus.
// It grants either the instruction fetcher or the load/store buffer, splits
// the access into 1-4 byte beats, assembles and extends read data, and
// returns it with a one-cycle done pulse.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both
// requesters contend. Without it the load/store buffer always wins.
module mem_bus_arbiter #(
  parameter int unsigned IF_BYTES = 4,
  parameter logic [1:0]  IO_SEL   = 2'b11
) (
  input logic              clk_in,
  input logic              rst_in,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [2:0] IF_BEATS = (IF_BYTES == 2) ? 3'd2 : 3'd4;

  state_t      state;
  logic        owner_ls;    // 1 = load/store owns the transaction
  logic [2:0]  beats;       // bytes in this transaction
  logic [2:0]  cnt;         // beat index (WRITE) or cycle index (READ)
  logic [31:0] base;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        io_q;        // store targets the IO window
  logic        wr_q;
  logic [31:0] rbuf;
  logic [31:0] mem_a_q;
  logic [7:0]  dout_q;
  logic        if_done_q;
  logic        ls_done_q;
  logic [31:0] if_data_q;
  logic [31:0] ls_rdata_q;

  logic        frz_q;       // previous cycle was frozen
  logic [7:0]  din_hold;    // byte present on mem_din when the freeze began

`ifdef ARB_ROUND_ROBIN_EN
  logic        prio_ls;     // 1 = load/store wins the next contended grant
`endif

  logic        grant_ls;
  logic        grant_if;
  logic        io_stall;
  logic [7:0]  cap_byte;
  logic [1:0]  cap_idx;
  logic [1:0]  nxt_idx;
  logic [31:0] rbuf_next;
  logic [31:0] load_ext;

  function automatic logic [2:0] ls_beats(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;   // word; the illegal size 3 is treated as word
    endcase
  endfunction

  // Pick the winner among pending requests. A flush in the same cycle blocks any grant.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (!bus.clear) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.ls_req && bus.if_req) begin
        grant_ls = prio_ls;
        grant_if = !prio_ls;
      end else begin
        grant_ls = bus.ls_req;
        grant_if = bus.if_req;
      end
`else
      grant_ls = bus.ls_req;
      grant_if = bus.if_req && !bus.ls_req;
`endif
    end
  end

  assign io_stall = io_q && bus.io_buffer_full;

  // After a freeze, mem_din already shows the data for the held address,
  // so the byte owed to the pending capture comes from the snapshot.
  assign cap_byte = frz_q ? din_hold : bus.mem_din;
  assign cap_idx  = 2'(cnt - 3'd1);
  assign nxt_idx  = 2'(cnt + 3'd1);

  // Read buffer with the byte captured in this cycle merged in.
  always_comb begin
    rbuf_next = rbuf;
    if (cnt != 3'd0) rbuf_next[{cap_idx, 3'b000} +: 8] = cap_byte;
  end

  // Sign- or zero-extend the assembled load to 32 bits.
  always_comb begin
    case (size_q)
      2'd0:    load_ext = {{24{signed_q & rbuf_next[7]}},  rbuf_next[7:0]};
      2'd1:    load_ext = {{16{signed_q & rbuf_next[15]}}, rbuf_next[15:0]};
      default: load_ext = rbuf_next;
    endcase
  end

  // Keep the mem_din byte from the first frozen cycle for use on resume.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frz_q    <= 1'b0;
      din_hold <= 8'h00;
    end else if (!bus.rdy_in) begin
      frz_q <= 1'b1;
      if (!frz_q) din_hold <= bus.mem_din;
    end else begin
      frz_q <= 1'b0;
    end
  end

  // Transaction FSM. It drives every registered bus and done output and holds everything while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state      <= IDLE;
      owner_ls   <= 1'b0;
      beats      <= 3'd0;
      cnt        <= 3'd0;
      base       <= 32'h0;
      wdata_q    <= 32'h0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      io_q       <= 1'b0;
      wr_q       <= 1'b0;
      rbuf       <= 32'h0;
      mem_a_q    <= 32'h0;
      dout_q     <= 8'h00;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'h0;
      ls_rdata_q <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_ls    <= 1'b1;
`endif
    end else if (bus.rdy_in) begin
      case (state)
        IDLE: begin
          if (grant_ls || grant_if) begin
            owner_ls <= grant_ls;
            base     <= grant_ls ? bus.ls_addr : bus.if_addr;
            mem_a_q  <= grant_ls ? bus.ls_addr : bus.if_addr;
            beats    <= grant_ls ? ls_beats(bus.ls_size) : IF_BEATS;
            cnt      <= 3'd0;
            rbuf     <= 32'h0;
            wdata_q  <= bus.ls_wdata;
            size_q   <= bus.ls_size;
            signed_q <= bus.ls_signed;
            io_q     <= grant_ls && (bus.ls_addr[17:16] == IO_SEL);
`ifdef ARB_ROUND_ROBIN_EN
            prio_ls  <= grant_if;
`endif
            if (grant_ls && bus.ls_we) begin
              state  <= WRITE;
              wr_q   <= 1'b1;
              dout_q <= bus.ls_wdata[7:0];
            end else begin
              state  <= READ;
            end
          end
        end

        READ: begin
          if (bus.clear) begin
            state <= IDLE;
          end else begin
            rbuf <= rbuf_next;
            if (cnt == beats) begin
              state <= DONE;
              if (owner_ls) begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= load_ext;
              end else begin
                if_done_q  <= 1'b1;
                if_data_q  <= rbuf_next;
              end
            end else begin
              if (cnt + 3'd1 < beats) mem_a_q <= base + 32'(cnt) + 32'd1;
              cnt <= cnt + 3'd1;
            end
          end
        end

        WRITE: begin
          // A store is already committed, so clear does not abort it.
          if (!io_stall) begin
            if (cnt + 3'd1 < beats) begin
              cnt     <= cnt + 3'd1;
              mem_a_q <= base + 32'(cnt) + 32'd1;
              dout_q  <= wdata_q[{nxt_idx, 3'b000} +: 8];
            end else begin
              state     <= DONE;
              wr_q      <= 1'b0;
              ls_done_q <= 1'b1;
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = dout_q;
  assign bus.mem_wr   = wr_q & bus.rdy_in & ~io_stall;
  assign bus.if_done  = if_done_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.busy     = (state != IDLE);

endmodule
